// File: rtl/w_stage_if.sv
// M-to-W stage bundle plus the register-file write port driven by the writeback stage.
interface w_stage_if;
  logic        M_en;
  logic        M_flush;
  logic [31:0] M_PC;
  logic        M_RegWrite;
  logic [4:0]  M_A3;
  logic [1:0]  M_WDSel;
  logic [31:0] M_ALUResult;
  logic [31:0] M_MemRD;
  logic [2:0]  M_LoadType;
  logic [4:0]  A3;
  logic [31:0] WD;
  logic [31:0] W_PC;
  logic [31:0] W_WriteCnt;

  modport master (
    output M_en, M_flush, M_PC, M_RegWrite, M_A3, M_WDSel, M_ALUResult, M_MemRD, M_LoadType,
    input  A3, WD, W_PC, W_WriteCnt
  );

  modport slave (
    input  M_en, M_flush, M_PC, M_RegWrite, M_A3, M_WDSel, M_ALUResult, M_MemRD, M_LoadType,
    output A3, WD, W_PC, W_WriteCnt
  );
endinterface

// File: rtl/w_stage_writeback.sv
// MIPS writeback stage: load extraction, write-data select, and registered register-file write port.
// A3 is forced to 0 for bubbles, non-writing instructions and $0 since the register file has no enable.
module w_stage_writeback #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic clk,
  input  logic reset,
  w_stage_if.slave wb
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic [AW-1:0] a3_q;
  logic [DW-1:0] wd_q;
  logic [DW-1:0] pc_q;
  logic [DW-1:0] cnt_q;

  logic [7:0]    load_byte;
  logic [15:0]   load_half;
  logic [DW-1:0] load_val;
  logic [DW-1:0] sel_data;
  logic [AW-1:0] a3_nxt;
  logic [DW-1:0] wd_nxt;

  // Byte/half extraction from the aligned word and sign/zero extension
  always_comb begin
    load_byte = 8'h00;
    load_half = 16'h0000;
    load_val  = wb.M_MemRD;
    case (wb.M_ALUResult[1:0])
      2'd0:    load_byte = wb.M_MemRD[7:0];
      2'd1:    load_byte = wb.M_MemRD[15:8];
      2'd2:    load_byte = wb.M_MemRD[23:16];
      default: load_byte = wb.M_MemRD[31:24];
    endcase
    load_half = wb.M_ALUResult[1] ? wb.M_MemRD[31:16] : wb.M_MemRD[15:0];
    case (wb.M_LoadType)
      3'b001:  load_val = {{24{load_byte[7]}}, load_byte};
      3'b010:  load_val = {24'h000000, load_byte};
      3'b011:  load_val = {{16{load_half[15]}}, load_half};
      3'b100:  load_val = {16'h0000, load_half};
      default: load_val = wb.M_MemRD;
    endcase
  end

  // Write-data source select and write suppression
  always_comb begin
    sel_data = wb.M_ALUResult;
    case (wb.M_WDSel)
      2'b01:   sel_data = load_val;
      2'b10:   sel_data = wb.M_PC + DW'(8);
      default: sel_data = wb.M_ALUResult;
    endcase
    a3_nxt = (wb.M_RegWrite && (wb.M_A3 != AW'(0))) ? wb.M_A3 : AW'(0);
    wd_nxt = (a3_nxt != AW'(0)) ? sel_data : DW'(0);
  end

  // Priority: reset > flush > stall > capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a3_q  <= AW'(0);
      wd_q  <= DW'(0);
      pc_q  <= RESET_PC;
      cnt_q <= DW'(0);
    end else if (wb.M_flush) begin
      a3_q  <= AW'(0);
      wd_q  <= DW'(0);
      pc_q  <= RESET_PC;
    end else if (wb.M_en) begin
      a3_q  <= a3_nxt;
      wd_q  <= wd_nxt;
      pc_q  <= wb.M_PC;
      if (a3_nxt != AW'(0)) begin
        cnt_q <= cnt_q + DW'(1);
      end
    end
  end

  assign wb.A3         = a3_q;
  assign wb.WD         = wd_q;
  assign wb.W_PC       = pc_q;
  assign wb.W_WriteCnt = cnt_q;

endmodule

// File: tb/tb_w_stage_writeback.sv
// Directed bench for w_stage_writeback; expected W contents are queued at drive time and checked after each edge.
module tb_w_stage_writeback;

  localparam logic [31:0] TB_RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] MEM_WORD    = 32'h80FF_7F01;

  typedef struct packed {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [31:0] cnt;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb_q[$];
  exp_t last_exp;
  logic [31:0] model_cnt;

  w_stage_if bus ();

  w_stage_writeback #(.RESET_PC(TB_RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".A3"},  32'(bus.A3), 32'(e.a3));
    chk({tag, ".WD"},  bus.WD, e.wd);
    chk({tag, ".PC"},  bus.W_PC, e.pc);
    chk({tag, ".CNT"}, bus.W_WriteCnt, e.cnt);
  endtask

  // Drive one M-stage instruction half a cycle before the capturing edge
  task automatic drive(input logic en, input logic flush, input logic [31:0] pc,
                       input logic rw, input logic [4:0] a3, input logic [1:0] wdsel,
                       input logic [31:0] alu, input logic [31:0] memrd, input logic [2:0] lt);
    @(negedge clk);
    bus.M_en        = en;
    bus.M_flush     = flush;
    bus.M_PC        = pc;
    bus.M_RegWrite  = rw;
    bus.M_A3        = a3;
    bus.M_WDSel     = wdsel;
    bus.M_ALUResult = alu;
    bus.M_MemRD     = memrd;
    bus.M_LoadType  = lt;
  endtask

  task automatic expect_write(input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
    exp_t e;
    if (a3 != 5'd0) model_cnt = model_cnt + 32'd1;
    e = '{a3: a3, wd: wd, pc: pc, cnt: model_cnt};
    last_exp = e;
    sb_q.push_back(e);
  endtask

  task automatic expect_hold();
    sb_q.push_back(last_exp);
  endtask

  task automatic expect_bubble();
    exp_t e;
    e = '{a3: 5'd0, wd: 32'd0, pc: TB_RESET_PC, cnt: model_cnt};
    last_exp = e;
    sb_q.push_back(e);
  endtask

  task automatic edge_check(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty observed 0 expected 1", tag);
    end else begin
      checks--;
      e = sb_q.pop_front();
      chk_all(tag, e);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    model_cnt = 32'd0;
    reset     = 1'b0;
    bus.M_en = 1'b1; bus.M_flush = 1'b0; bus.M_PC = 32'd0; bus.M_RegWrite = 1'b0;
    bus.M_A3 = 5'd0; bus.M_WDSel = 2'b00; bus.M_ALUResult = 32'd0; bus.M_MemRD = 32'd0;
    bus.M_LoadType = 3'b000;

    // Asynchronous reset between edges
    #2 reset = 1'b1;
    #1;
    chk_all("reset", '{a3: 5'd0, wd: 32'd0, pc: TB_RESET_PC, cnt: 32'd0});
    @(negedge clk);
    reset = 1'b0;

    drive(1, 0, 32'h0000_3000, 1, 5'd8, 2'b00, 32'h1234_5678, 32'h0, 3'b000);
    expect_write(5'd8, 32'h1234_5678, 32'h0000_3000);
    edge_check("alu");

    drive(1, 0, 32'h0000_3004, 1, 5'd9, 2'b01, 32'h0000_1002, MEM_WORD, 3'b001);
    expect_write(5'd9, 32'hFFFF_FFFF, 32'h0000_3004);
    edge_check("lb_off2");

    drive(1, 0, 32'h0000_3008, 1, 5'd10, 2'b01, 32'h0000_1003, MEM_WORD, 3'b010);
    expect_write(5'd10, 32'h0000_0080, 32'h0000_3008);
    edge_check("lbu_off3");

    drive(1, 0, 32'h0000_300C, 1, 5'd11, 2'b01, 32'h0000_1003, MEM_WORD, 3'b011);
    expect_write(5'd11, 32'hFFFF_80FF, 32'h0000_300C);
    edge_check("lh_off3");

    drive(1, 0, 32'h0000_3010, 1, 5'd12, 2'b01, 32'h0000_1000, MEM_WORD, 3'b100);
    expect_write(5'd12, 32'h0000_7F01, 32'h0000_3010);
    edge_check("lhu_off0");

    drive(1, 0, 32'h0000_3014, 1, 5'd13, 2'b01, 32'h0000_1001, MEM_WORD, 3'b111);
    expect_write(5'd13, MEM_WORD, 32'h0000_3014);
    edge_check("lw_badtype");

    drive(1, 0, 32'h0000_3018, 1, 5'd14, 2'b11, 32'hCAFE_F00D, MEM_WORD, 3'b001);
    expect_write(5'd14, 32'hCAFE_F00D, 32'h0000_3018);
    edge_check("wdsel_rsvd");

    drive(1, 0, 32'h0000_301C, 1, 5'd0, 2'b00, 32'hDEAD_BEEF, 32'h0, 3'b000);
    expect_write(5'd0, 32'd0, 32'h0000_301C);
    edge_check("zero_reg");

    drive(1, 0, 32'h0000_3020, 0, 5'd5, 2'b00, 32'hDEAD_BEEF, 32'h0, 3'b000);
    expect_write(5'd0, 32'd0, 32'h0000_3020);
    edge_check("no_write");

    drive(1, 0, 32'hFFFF_FFFC, 1, 5'd31, 2'b10, 32'h1111_1111, 32'h0, 3'b000);
    expect_write(5'd31, 32'h0000_0004, 32'hFFFF_FFFC);
    edge_check("jal_wrap");

    drive(1, 0, 32'h0000_4000, 1, 5'd7, 2'b00, 32'hAAAA_5555, 32'h0, 3'b000);
    expect_write(5'd7, 32'hAAAA_5555, 32'h0000_4000);
    edge_check("pre_stall");

    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 32'h0000_5000 + 32'(i), 1, 5'd20 + 5'(i), 2'b00, 32'h0BAD_0000, 32'h0, 3'b000);
      expect_hold();
      edge_check("stall");
    end

    drive(0, 1, 32'h0000_6000, 1, 5'd21, 2'b00, 32'h0BAD_0001, 32'h0, 3'b000);
    expect_bubble();
    edge_check("flush_stall");

    drive(1, 0, 32'h0000_6004, 1, 5'd3, 2'b01, 32'h0000_0001, MEM_WORD, 3'b001);
    expect_write(5'd3, 32'h0000_007F, 32'h0000_6004);
    edge_check("post_flush");

    // Reset mid-stall takes effect without a clock edge
    drive(0, 0, 32'h0000_7000, 1, 5'd4, 2'b00, 32'h0000_0042, 32'h0, 3'b000);
    #2 reset = 1'b1;
    #1;
    chk_all("reset_mid", '{a3: 5'd0, wd: 32'd0, pc: TB_RESET_PC, cnt: 32'd0});
    model_cnt = 32'd0;
    @(negedge clk);
    reset = 1'b0;

    drive(1, 0, 32'h0000_7004, 1, 5'd6, 2'b00, 32'h0000_0042, 32'h0, 3'b000);
    expect_write(5'd6, 32'h0000_0042, 32'h0000_7004);
    edge_check("after_reset");

    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/w_stage_writeback.md
# w_stage_writeback

Writeback (W) stage of the five-stage MIPS pipeline: the producer side of the register-file write port. It captures the M-stage result on each clock, performs load byte/half extraction and write-data selection, and drives the register file's write address, data, and PC trace inputs from registers. The register file has no write enable and writes whenever its write address is non-zero, so this block is solely responsible for forcing A3 to 0 on bubbles, non-writing instructions and $0 targets.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, value loaded into W_PC on reset and flush.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- M_en  in  1  stage enable; 0 = stall (hold W contents).
- M_flush  in  1  load a bubble into W.
- M_PC  in  32  PC of the M-stage instruction.
- M_RegWrite  in  1  instruction writes the register file.
- M_A3  in  5  destination register number.
- M_WDSel  in  2  00 = ALU result, 01 = memory load, 10 = M_PC+8, 11 = reserved (treated as 00).
- M_ALUResult  in  32  ALU/address result.
- M_MemRD  in  32  raw aligned word from data memory.
- M_LoadType  in  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu, others = lw.
- A3  out  5  register-file write address; 0 = no write.
- WD  out  32  register-file write data.
- W_PC  out  32  PC of the instruction in W, for the write trace.
- W_WriteCnt  out  32  count of non-zero A3 values captured into W.

## Operation
- Byte offset is M_ALUResult[1:0]. lb/lbu select byte M_MemRD[8*off+7:8*off]. lh/lhu select M_MemRD[31:16] if off[1] else [15:0]. off[0] is ignored for halves. lb/lh sign-extend; lbu/lhu zero-extend.
- Next write data: ALU result, the extended load value, or M_PC+8 (32-bit, wraps mod 2^32), selected by M_WDSel.
- Next A3 = (M_RegWrite && M_A3 != 0) ? M_A3 : 0. When next A3 = 0, next WD = 0.
- Register update priority per edge: reset > M_flush > !M_en (hold all) > capture.
- Flush loads A3 = 0, WD = 0, W_PC = RESET_PC. W_WriteCnt is unchanged.
- Capture: A3, WD, W_PC <= computed values. W_WriteCnt increments by 1 when the captured A3 != 0, wrapping from 0xFFFF_FFFF to 0.
- A3, WD, W_PC and W_WriteCnt are driven directly from flops. There is no combinational path from any input to any output.

## Timing
- Reset (async) value of every output: A3 = 0, WD = 0, W_PC = RESET_PC, W_WriteCnt = 0. Applies without waiting for a clock edge. Deassertion takes effect at the next rising edge.
- Latency: M inputs sampled at edge N appear on the outputs after edge N. The register file commits the write at edge N+1, and its read bypass sees WD during cycle N..N+1.
- Stall: while M_en = 0, outputs hold. If A3 != 0 during the stall, the register file rewrites the same value every cycle, which is harmless. W_WriteCnt does not advance during a stall.
- Simultaneous M_flush and M_en = 0: the flush wins and a bubble is loaded.
- Reset asserted mid-stall or mid-flush: reset wins and the state is cleared.

## Test plan
- Reset: assert reset asynchronously between edges -> A3 = 0, WD = 0, W_PC = 0, W_WriteCnt = 0 immediately.
- ALU write: M_RegWrite = 1, M_A3 = 8, M_WDSel = 00, M_ALUResult = 0x1234_5678, M_PC = 0x3000 -> after the edge: A3 = 8, WD = 0x1234_5678, W_PC = 0x3000, W_WriteCnt = 1.
- Loads with M_MemRD = 0x80FF_7F01:
  - lb, off 2 -> WD = 0xFFFF_FFFF.
  - lbu, off 3 -> WD = 0x0000_0080.
  - lh, off 3 -> WD = 0xFFFF_80FF.
  - lhu, off 0 -> WD = 0x0000_7F01.
- $0 and no-write suppression: M_A3 = 0 with M_RegWrite = 1, then M_A3 = 5 with M_RegWrite = 0 -> A3 = 0 and WD = 0 both times; W_WriteCnt unchanged.
- Jal link: M_WDSel = 10, M_PC = 0xFFFF_FFFC, M_A3 = 31 -> WD = 0x0000_0004, A3 = 31.
- Stall and flush priority: hold a write with M_en = 0 for 3 cycles -> outputs and count frozen. Then assert M_flush with M_en = 0 -> A3 = 0, WD = 0, W_PC = RESET_PC, count unchanged.
